// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory-port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the arbiter; slave = arbiter, master = requesters/memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_valid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_gnt, i_valid, i_rdata, i_err, d_gnt, d_valid, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_gnt, i_valid, i_rdata, i_err, d_gnt, d_valid, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_timer.sv
// Watchdog counter: counts enabled cycles, flags when TIMEOUT-1 is reached.
module mem_arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_cnt <= '0;
    else if (i_clr)                 r_cnt <= '0;
    else if (i_en && !o_expired)    r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF and MEM accesses onto one variable-latency memory port with a hang watchdog.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed MEM-over-IF priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          busy
);
  state_t            r_state, w_next;
  owner_t            r_owner, w_win;
  logic              w_any, w_i_gnt, w_d_gnt, w_expired, w_done;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mem_req, r_busy;
  logic              r_i_valid, r_i_err, r_d_valid, r_d_err;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata;

  assign w_any  = bus.i_req | bus.d_req;
  assign w_done = (r_state == WAIT) && (bus.mem_ready || w_expired);

`ifdef MEM_ARB_RR_EN
  owner_t r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_last <= OWN_IF;
    else if (r_state == IDLE && w_any) r_last <= w_win;
  end

  // Contention goes to whoever did not win last time.
  always_comb begin
    w_win = bus.d_req ? OWN_MEM : OWN_IF;
    if (bus.i_req && bus.d_req) w_win = (r_last == OWN_MEM) ? OWN_IF : OWN_MEM;
  end
`else
  always_comb w_win = bus.d_req ? OWN_MEM : OWN_IF;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    case (r_state)
      IDLE: if (w_any) begin
        w_next  = WAIT;
        w_i_gnt = (w_win == OWN_IF);
        w_d_gnt = (w_win == OWN_MEM);
      end
      WAIT:    if (w_done) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state != WAIT),
    .i_en      ((r_state == WAIT) && !bus.mem_ready),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner   <= OWN_IF;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_mem_req <= 1'b0;
      r_busy    <= 1'b0;
      r_i_valid <= 1'b0;
      r_i_err   <= 1'b0;
      r_i_rdata <= '0;
      r_d_valid <= 1'b0;
      r_d_err   <= 1'b0;
      r_d_rdata <= '0;
    end else begin
      r_mem_req <= (w_next == WAIT);
      r_busy    <= (w_next != IDLE);
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      if (r_state == IDLE && w_any) begin
        r_owner <= w_win;
        r_addr  <= (w_win == OWN_MEM) ? bus.d_addr : bus.i_addr;
        r_we    <= (w_win == OWN_MEM) && bus.d_we;
        r_wdata <= (w_win == OWN_MEM) ? bus.d_wdata : '0;
      end
      // A ready arriving on the expiry cycle still completes normally.
      if (w_done) begin
        if (r_owner == OWN_IF) begin
          r_i_valid <= 1'b1;
          r_i_err   <= !bus.mem_ready;
          r_i_rdata <= bus.mem_ready ? bus.mem_rdata : DATA_W'(NOP_INSTR);
        end else begin
          r_d_valid <= 1'b1;
          r_d_err   <= !bus.mem_ready;
          r_d_rdata <= bus.mem_ready ? bus.mem_rdata : '0;
        end
      end
    end
  end

  assign bus.i_gnt     = w_i_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.i_valid   = r_i_valid;
  assign bus.i_err     = r_i_err;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_valid   = r_d_valid;
  assign bus.d_err     = r_d_err;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign busy          = r_busy;
endmodule
